// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and edge-detects the Basys3 push-buttons.
// Define BTN_AUTOREPEAT_EN to build the shared hold-to-repeat engine; otherwise btn_repeat is 0.
module btn_conditioner #(
  parameter int N_BTN           = 5,
  parameter int CLK_HZ          = 1_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             btn_repeat
);

  localparam int DB_TICKS = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DBW = $clog2(DB_TICKS + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

  logic [N_BTN-1:0] s1, s2;
  logic [N_BTN-1:0] level_d, rise_d, fall_d, press_d;
  logic [DBW-1:0]   cnt   [N_BTN];
  logic [DBW-1:0]   cnt_d [N_BTN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // A single cycle where the synced input agrees with the level restarts the count.
  always_comb begin
    level_d = btn_level;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt[i];
      if (s2[i] == btn_level[i]) begin
        cnt_d[i] = '0;
      end else if (cnt[i] == DB_LAST) begin
        level_d[i] = s2[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt[i] + DBW'(1);
      end
    end
    rise_d = level_d & ~btn_level;
    fall_d = btn_level & ~level_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
    end else begin
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= fall_d;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_d[i];
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, DELAY, RATE} rpt_state_t;

  localparam int RD_TICKS = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RR_TICKS = CLK_HZ / 1000 * REPEAT_RATE_MS;
  localparam int RPT_MAX  = (RD_TICKS > RR_TICKS) ? RD_TICKS : RR_TICKS;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam int SW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(RD_TICKS - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(RR_TICKS - 1);

  rpt_state_t      state, state_d;
  logic [RW-1:0]   rcnt, rcnt_d;
  logic [SW-1:0]   sel_d;
  logic            fire;

  // Highest held bit wins, so centre overrides the directional buttons.
  function automatic logic [SW-1:0] top_bit(input logic [N_BTN-1:0] v);
    top_bit = '0;
    for (int i = 0; i < N_BTN; i++) if (v[i]) top_bit = SW'(i);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rcnt       <= '0;
      btn_repeat <= 1'b0;
    end else begin
      state      <= state_d;
      rcnt       <= rcnt_d;
      btn_repeat <= fire;
    end
  end

  // Decisions use the level being loaded this cycle, so an edge press always beats a repeat.
  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    fire    = 1'b0;
    sel_d   = top_bit(level_d);
    if (level_d == '0) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else if (rise_d != '0 || sel_d != top_bit(btn_level) || state == IDLE) begin
      state_d = DELAY;
      rcnt_d  = '0;
    end else begin
      case (state)
        DELAY: begin
          if (rcnt == RD_LAST) begin
            fire    = 1'b1;
            state_d = RATE;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end
        RATE: begin
          if (rcnt == RR_LAST) begin
            fire   = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt + RW'(1);
          end
        end
        default: begin
          state_d = DELAY;
          rcnt_d  = '0;
        end
      endcase
    end
    press_d = rise_d;
    if (fire) press_d[sel_d] = 1'b1;
  end
`else
  always_comb press_d = rise_d;
  assign btn_repeat = 1'b0;
`endif

endmodule
